// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator.
// Turns a simple command/response handshake into one AXI4-Lite read or
// write at a time. Every AXI and response output is driven from a flop.
// Next-state and next-output values are computed together in one
// combinational block and captured in one register block.
module axi_lite_master #(
  parameter int AXI_ADDR_BW_p = 12,
  parameter int DATA_BW_p     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // command / response side
  input  logic                     i_cmd_valid,
  input  logic                     i_cmd_write,
  input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
  input  logic [DATA_BW_p-1:0]     i_cmd_wdata,
  output logic                     o_cmd_ready,
  output logic                     o_rsp_valid,
  output logic [DATA_BW_p-1:0]     o_rsp_rdata,
  output logic [1:0]               o_rsp_resp,
  output logic                     o_rsp_write,
  input  logic                     i_rsp_ready,
  // AXI4-Lite write address / data / response
  output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
  output logic                     o_axi_awvalid,
  input  logic                     i_axi_awready,
  output logic [DATA_BW_p-1:0]     o_axi_wdata,
  output logic                     o_axi_wvalid,
  input  logic                     i_axi_wready,
  input  logic [1:0]               i_axi_bresp,
  input  logic                     i_axi_bvalid,
  output logic                     o_axi_bready,
  // AXI4-Lite read address / data
  output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
  output logic                     o_axi_arvalid,
  input  logic                     i_axi_arready,
  input  logic [DATA_BW_p-1:0]     i_axi_rdata,
  input  logic [1:0]               i_axi_rresp,
  input  logic                     i_axi_rvalid,
  output logic                     o_axi_rready,
  output logic                     o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } state_t;

  state_t                   state_r, state_n;
  logic [AXI_ADDR_BW_p-1:0] awaddr_r, awaddr_n;
  logic [AXI_ADDR_BW_p-1:0] araddr_r, araddr_n;
  logic [DATA_BW_p-1:0]     wdata_r, wdata_n;
  logic                     awvalid_r, awvalid_n;
  logic                     wvalid_r, wvalid_n;
  logic                     aw_done_r, aw_done_n;
  logic                     w_done_r, w_done_n;
  logic                     bready_r, bready_n;
  logic                     arvalid_r, arvalid_n;
  logic                     rready_r, rready_n;
  logic                     cmd_ready_r, cmd_ready_n;
  logic                     rsp_valid_r, rsp_valid_n;
  logic [DATA_BW_p-1:0]     rsp_rdata_r, rsp_rdata_n;
  logic [1:0]               rsp_resp_r, rsp_resp_n;
  logic                     rsp_write_r, rsp_write_n;
  logic                     busy_r, busy_n;

  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic ar_hs_s;
  logic r_hs_s;

  assign aw_hs_s = awvalid_r & i_axi_awready;
  assign w_hs_s  = wvalid_r  & i_axi_wready;
  assign b_hs_s  = bready_r  & i_axi_bvalid;
  assign ar_hs_s = arvalid_r & i_axi_arready;
  assign r_hs_s  = rready_r  & i_axi_rvalid;

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_n     = state_r;
    awaddr_n    = awaddr_r;
    araddr_n    = araddr_r;
    wdata_n     = wdata_r;
    awvalid_n   = awvalid_r;
    wvalid_n    = wvalid_r;
    aw_done_n   = aw_done_r;
    w_done_n    = w_done_r;
    bready_n    = bready_r;
    arvalid_n   = arvalid_r;
    rready_n    = rready_r;
    cmd_ready_n = cmd_ready_r;
    rsp_valid_n = rsp_valid_r;
    rsp_rdata_n = rsp_rdata_r;
    rsp_resp_n  = rsp_resp_r;
    rsp_write_n = rsp_write_r;

    case (state_r)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          cmd_ready_n = 1'b0;
          if (i_cmd_write) begin
            awaddr_n  = i_cmd_addr;
            wdata_n   = i_cmd_wdata;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = ST_WRITE;
          end else begin
            araddr_n  = i_cmd_addr;
            arvalid_n = 1'b1;
            state_n   = ST_READ;
          end
        end else begin
          cmd_ready_n = 1'b1;
        end
      end

      ST_WRITE: begin
        // AW and W complete independently; each valid drops after its own handshake.
        aw_done_n = aw_done_r | aw_hs_s;
        w_done_n  = w_done_r  | w_hs_s;
        if (aw_hs_s) begin
          awvalid_n = 1'b0;
        end else begin
          awvalid_n = awvalid_r;
        end
        if (w_hs_s) begin
          wvalid_n = 1'b0;
        end else begin
          wvalid_n = wvalid_r;
        end
        // bready only after both channels are done, so an early bvalid is ignored.
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = ST_WRESP;
        end else begin
          bready_n = 1'b0;
        end
      end

      ST_WRESP: begin
        if (b_hs_s) begin
          bready_n    = 1'b0;
          rsp_resp_n  = i_axi_bresp;
          rsp_rdata_n = {DATA_BW_p{1'b0}};
          rsp_write_n = 1'b1;
          rsp_valid_n = 1'b1;
          state_n     = ST_RSP;
        end else begin
          bready_n = 1'b1;
        end
      end

      ST_READ: begin
        if (ar_hs_s) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = ST_RDATA;
        end else begin
          arvalid_n = 1'b1;
        end
      end

      ST_RDATA: begin
        if (r_hs_s) begin
          rready_n    = 1'b0;
          rsp_rdata_n = i_axi_rdata;
          rsp_resp_n  = i_axi_rresp;
          rsp_write_n = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = ST_RSP;
        end else begin
          rready_n = 1'b1;
        end
      end

      ST_RSP: begin
        // Response fields are held; a new command waits for this handshake.
        if (i_rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = ST_IDLE;
        end else begin
          rsp_valid_n = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: drop every handshake and return to idle.
        awvalid_n   = 1'b0;
        wvalid_n    = 1'b0;
        bready_n    = 1'b0;
        arvalid_n   = 1'b0;
        rready_n    = 1'b0;
        rsp_valid_n = 1'b0;
        cmd_ready_n = 1'b1;
        state_n     = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers; asynchronous reset drops every valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      awaddr_r    <= {AXI_ADDR_BW_p{1'b0}};
      araddr_r    <= {AXI_ADDR_BW_p{1'b0}};
      wdata_r     <= {DATA_BW_p{1'b0}};
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_BW_p{1'b0}};
      rsp_resp_r  <= 2'b00;
      rsp_write_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      awaddr_r    <= awaddr_n;
      araddr_r    <= araddr_n;
      wdata_r     <= wdata_n;
      awvalid_r   <= awvalid_n;
      wvalid_r    <= wvalid_n;
      aw_done_r   <= aw_done_n;
      w_done_r    <= w_done_n;
      bready_r    <= bready_n;
      arvalid_r   <= arvalid_n;
      rready_r    <= rready_n;
      cmd_ready_r <= cmd_ready_n;
      rsp_valid_r <= rsp_valid_n;
      rsp_rdata_r <= rsp_rdata_n;
      rsp_resp_r  <= rsp_resp_n;
      rsp_write_r <= rsp_write_n;
      busy_r      <= busy_n;
    end
  end

  assign o_cmd_ready   = cmd_ready_r;
  assign o_rsp_valid   = rsp_valid_r;
  assign o_rsp_rdata   = rsp_rdata_r;
  assign o_rsp_resp    = rsp_resp_r;
  assign o_rsp_write   = rsp_write_r;
  assign o_axi_awaddr  = awaddr_r;
  assign o_axi_awvalid = awvalid_r;
  assign o_axi_wdata   = wdata_r;
  assign o_axi_wvalid  = wvalid_r;
  assign o_axi_bready  = bready_r;
  assign o_axi_araddr  = araddr_r;
  assign o_axi_arvalid = arvalid_r;
  assign o_axi_rready  = rready_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: table-driven bench with a delay-programmable AXI4-Lite slave.
module tb_axi_lite_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_write, cmd_ready;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, busy;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  axi_lite_master #(.AXI_ADDR_BW_p(12), .DATA_BW_p(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr),
    .i_cmd_wdata(cmd_wdata), .o_cmd_ready(cmd_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
    .o_rsp_write(rsp_write), .i_rsp_ready(rsp_ready),
    .o_axi_awaddr(awaddr), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(bready),
    .o_axi_araddr(araddr), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid),
    .o_axi_rready(rready), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- slave model ----------------
  int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
  bit          early_b;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_got, w_got, ar_got;
  logic [11:0] aw_q, ar_q;
  logic [31:0] w_q;
  logic [31:0] mem [16];
  int          b_hs_cnt, r_hs_cnt;

  assign awready = (aw_cnt == aw_delay);
  assign wready  = (w_cnt == w_delay);
  assign bvalid  = early_b | (aw_got & w_got & (b_cnt == b_delay));
  assign bresp   = (aw_q == 12'h000) ? 2'b10 : 2'b00;
  assign arready = (ar_cnt == ar_delay);
  assign rvalid  = ar_got & (r_cnt == r_delay);
  assign rresp   = (ar_q == 12'h008) ? 2'b10 : 2'b00;
  assign rdata   = (ar_q == 12'h008) ? 32'hDEAD_DEAD : mem[ar_q[5:2]];

  // Slave handshake tracking, wait-state counters and register storage.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_q <= 12'h000; ar_q <= 12'h000; w_q <= 32'h0;
      b_hs_cnt <= 0; r_hs_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else begin
      if (awvalid && awready) begin
        aw_cnt <= 0; aw_got <= 1'b1; aw_q <= awaddr;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_cnt <= 0; w_got <= 1'b1; w_q <= wdata;
      end else if (wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (bvalid && bready) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        b_hs_cnt <= b_hs_cnt + 1;
        mem[aw_q[5:2]] <= w_q;
      end else if (aw_got && w_got) begin
        b_cnt <= b_cnt + 1;
      end
      if (arvalid && arready) begin
        ar_cnt <= 0; ar_got <= 1'b1; ar_q <= araddr;
      end else if (arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (rvalid && rready) begin
        ar_got <= 1'b0; r_cnt <= 0;
        r_hs_cnt <= r_hs_cnt + 1;
      end else if (ar_got) begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int checks;
  int errors;

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          aw_d, w_d, b_d, ar_d, r_d, rsp_d;
    int          lat;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one command end to end; entered and left on a falling edge.
  task automatic run(input vec_t v, input int idx);
    int guard, cyc, awc, wc, arc, bad_addr, bad_ready, bad_bready, bad_hold, b0, r0;
    string tag;
    tag = $sformatf("v%0d", idx);
    aw_delay = v.aw_d; w_delay = v.w_d; b_delay = v.b_d;
    ar_delay = v.ar_d; r_delay = v.r_d;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_cmd_wait"}, guard, 0);
    b0 = b_hs_cnt; r0 = r_hs_cnt;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
    cyc = 1; awc = 0; wc = 0; arc = 0;
    bad_addr = 0; bad_ready = 0; bad_bready = 0; bad_hold = 0;
    while (!rsp_valid && cyc < 200) begin
      if (awvalid) begin awc++; if (awaddr !== v.addr) bad_addr++; end
      if (wvalid) begin wc++; if (wdata !== v.wdata) bad_addr++; end
      if (arvalid) begin arc++; if (araddr !== v.addr) bad_addr++; end
      if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
      if (bready && (awvalid || wvalid)) bad_bready++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, v.lat);
    check({tag, "_awvalid_cycles"}, awc, v.write ? v.aw_d + 1 : 0);
    check({tag, "_wvalid_cycles"}, wc, v.write ? v.w_d + 1 : 0);
    check({tag, "_arvalid_cycles"}, arc, v.write ? 0 : v.ar_d + 1);
    check({tag, "_addr_data_stable"}, bad_addr, 0);
    check({tag, "_busy_ready_low"}, bad_ready, 0);
    check({tag, "_bready_early"}, bad_bready, 0);
    for (int k = 0; k < v.rsp_d; k++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rdata || rsp_resp !== v.exp_resp ||
          rsp_write !== v.write || cmd_ready !== 1'b0) bad_hold++;
      @(negedge clk);
    end
    check({tag, "_rsp_hold"}, bad_hold, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, "_rsp_resp"}, rsp_resp, v.exp_resp);
    check({tag, "_rsp_write"}, rsp_write, v.write);
    check({tag, "_ready_at_hs"}, cmd_ready, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_cleared"}, rsp_valid, 0);
    check({tag, "_cmd_ready_back"}, cmd_ready, 1);
    check({tag, "_busy_clear"}, busy, 0);
    check({tag, "_b_count"}, b_hs_cnt - b0, v.write ? 1 : 0);
    check({tag, "_r_count"}, r_hs_cnt - r0, v.write ? 0 : 1);
  endtask

  initial begin
    vec_t v;
    checks = 0; errors = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h000;
    cmd_wdata = 32'h0; rsp_ready = 1'b0; early_b = 1'b0;
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;

    //          wr    addr     wdata          aw w b ar r rsp lat rdata          resp
    vecs[0] = '{1'b1, 12'h00C, 32'h0000_0035, 0, 0, 0, 0, 0, 0, 3, 32'h0,         2'b00};
    vecs[1] = '{1'b0, 12'h00C, 32'h0,         0, 0, 0, 0, 0, 0, 3, 32'h0000_0035, 2'b00};
    vecs[2] = '{1'b1, 12'h000, 32'h0000_0001, 0, 0, 0, 0, 0, 0, 3, 32'h0,         2'b10};
    vecs[3] = '{1'b0, 12'h008, 32'h0,         0, 0, 0, 0, 0, 0, 3, 32'hDEAD_DEAD, 2'b10};
    vecs[4] = '{1'b1, 12'h010, 32'hA5A5_0001, 5, 0, 0, 0, 0, 0, 8, 32'h0,         2'b00};
    vecs[5] = '{1'b1, 12'h014, 32'h1234_5678, 0, 5, 0, 0, 0, 0, 8, 32'h0,         2'b00};
    vecs[6] = '{1'b0, 12'h010, 32'h0,         0, 0, 0, 0, 4, 3, 7, 32'hA5A5_0001, 2'b00};
    vecs[7] = '{1'b0, 12'h014, 32'h0,         0, 0, 0, 0, 0, 0, 3, 32'h1234_5678, 2'b00};
    vecs[8] = '{1'b1, 12'h018, 32'hCAFE_F00D, 1, 3, 2, 0, 0, 0, 8, 32'h0,         2'b00};
    vecs[9] = '{1'b0, 12'h018, 32'h0,         0, 0, 0, 2, 0, 1, 5, 32'hCAFE_F00D, 2'b00};

    #22;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_busy", busy, 0);
    check("rst_addrs", {8'h00, awaddr, araddr}, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_rsp_fields", {rsp_rdata[28:0], rsp_resp, rsp_write}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run(vecs[i], i);

    // bvalid raised before AW/W finish must be ignored until both complete.
    early_b = 1'b1;
    v = '{1'b1, 12'h01C, 32'h0000_0077, 3, 3, 0, 0, 0, 0, 6, 32'h0, 2'b00};
    run(v, 10);
    early_b = 1'b0;

    // Reset while AW is stalled: valids drop without a clock edge.
    aw_delay = 10; w_delay = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_awvalid", awvalid, 1);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    aw_delay = 0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    v = '{1'b1, 12'h004, 32'h0000_0004, 0, 0, 0, 0, 0, 0, 3, 32'h0, 2'b00};
    run(v, 11);
    v = '{1'b0, 12'h004, 32'h0, 0, 0, 0, 0, 0, 0, 3, 32'h0000_0004, 2'b00};
    run(v, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
